// File: rtl/rca64_adder.sv
// rca64_adder: WIDTH-bit ripple-carry adder with a registered output stage.
// The combinational core is an explicit chain of full-adder cells, one per bit,
// so the carry ripples from bit 0 up to bit WIDTH-1. Sum, carry-out and signed
// overflow are captured on a rising clock edge that sees in_valid high.
//
// Handshake: in_valid qualifies a, b and cin at the rising edge where it is
// sampled high. The block is always ready, so there is no ready signal.
// out_valid is high for exactly the one cycle after each accepted input.
// Results hold their last value while in_valid is low.

// Single-bit full adder cell used to build the ripple chain.
module rca64_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic p;

  // Propagate term is shared by the sum bit and the carry.
  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);
endmodule

module rca64_adder #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid
);

  // Carry chain: c[0] is the carry in, c[WIDTH] is the carry out of the top bit.
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;
  logic             cout_comb;
  logic             ovf_comb;

  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q;
  logic             ovf_d, ovf_q;
  logic             out_valid_d, out_valid_q;

  assign c[0] = cin;

  // One full-adder cell per bit; carry from bit i feeds bit i+1.
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    rca64_fa u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  // Signed overflow: the carry into the sign bit differs from the carry out of it.
  assign cout_comb = c[WIDTH];
  assign ovf_comb  = c[WIDTH] ^ c[WIDTH-1];

  // Next-state: capture on a valid strobe, otherwise hold the previous result.
  always_comb begin
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      sum_d  = s;
      cout_d = cout_comb;
      ovf_d  = ovf_comb;
    end
  end

  // Output registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rca64_adder.sv
// tb_rca64_adder: directed and random checks of rca64_adder against a
// 65-bit reference sum, with a queue holding results awaiting their output cycle.
module tb_rca64_adder;

  localparam int W = 64;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         out_valid;

  // Expected entries are {ovf, cout, sum}.
  logic [W+1:0] exp_q[$];
  logic [W+1:0] held;
  int           n_cmp;
  int           n_bad;

  rca64_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .out_valid (out_valid)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model, written independently of the cell chain.
  function automatic logic [W+1:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic ci);
    logic [W:0]   full;
    logic         v;
    full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    v    = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
    return {v, full[W], full[W-1:0]};
  endfunction

  task automatic check(input string tag, input logic [W+1:0] obs, input logic [W+1:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Driver: present one cycle of stimulus (called at posedge+1), wait for the
  // capturing edge, and record the expected result if it was accepted.
  task automatic step(input logic v, input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic ci);
    in_valid = v;
    a        = v ? x : 'x;
    b        = v ? y : 'x;
    cin      = v ? ci : 1'bx;
    @(posedge clk);
    if (v && rst_n) exp_q.push_back(ref_add(x, y, ci));
    #1;
  endtask

  // Scoreboard: on every falling edge, check reset, out_valid timing,
  // captured results and held values.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset_out", {ovf, cout, sum}, '0);
      check("reset_vld", {{(W+1){1'b0}}, out_valid}, '0);
      exp_q.delete();
      held = '0;
    end else begin
      check("out_valid", {{(W+1){1'b0}}, out_valid},
            {{(W+1){1'b0}}, exp_q.size() != 0});
      if (exp_q.size() != 0) begin
        held = exp_q.pop_front();
        check("result", {ovf, cout, sum}, held);
      end else begin
        check("hold", {ovf, cout, sum}, held);
      end
    end
  end

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    held     = '0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;

    // Reset held with random inputs and toggling in_valid.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'(i % 2);
      a        = {$urandom, $urandom};
      b        = {$urandom, $urandom};
      cin      = 1'($urandom_range(0, 1));
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // First capture after release.
    step(1'b1, 64'd1, 64'd1, 1'b0);
    check("first_sum", {ovf, cout, sum}, {2'b00, 64'd2});
    check("first_vld", {{(W+1){1'b0}}, out_valid}, {{(W+1){1'b0}}, 1'b1});

    // Basic add, then an idle cycle that must hold the sum.
    step(1'b1, 64'h000000000123cdef, 64'h123456789abcdef0, 1'b0);
    check("basic_add", {ovf, cout, sum}, {2'b00, 64'h123456789BE0ACDF});
    step(1'b0, '0, '0, 1'b0);
    check("basic_hold", {ovf, cout, sum}, {2'b00, 64'h123456789BE0ACDF});
    check("basic_vld0", {{(W+1){1'b0}}, out_valid}, '0);

    // Full carry ripple.
    step(1'b1, 64'hFFFFFFFFFFFFFFFF, 64'd0, 1'b1);
    check("ripple_zero", {ovf, cout, sum}, {2'b01, 64'd0});
    step(1'b1, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b1);
    check("ripple_ones", {ovf, cout, sum}, {2'b01, 64'hFFFFFFFFFFFFFFFF});

    // Signed overflow, both directions.
    step(1'b1, 64'h7FFFFFFFFFFFFFFF, 64'd1, 1'b0);
    check("ovf_pos", {ovf, cout, sum}, {2'b10, 64'h8000000000000000});
    step(1'b1, 64'h8000000000000000, 64'h8000000000000000, 1'b0);
    check("ovf_neg", {ovf, cout, sum}, {2'b11, 64'd0});
    step(1'b0, '0, '0, 1'b0);

    // Back-to-back.
    step(1'b1, 64'd1, 64'd2, 1'b0);
    check("b2b_0", {ovf, cout, sum}, {2'b00, 64'd3});
    step(1'b1, 64'd10, 64'd20, 1'b1);
    check("b2b_1", {ovf, cout, sum}, {2'b00, 64'd31});
    step(1'b1, 64'hFFFFFFFFFFFFFFFF, 64'd2, 1'b0);
    check("b2b_2", {ovf, cout, sum}, {2'b01, 64'd1});
    check("b2b_vld", {{(W+1){1'b0}}, out_valid}, {{(W+1){1'b0}}, 1'b1});
    step(1'b0, '0, '0, 1'b0);

    // Reset mid-operation: the pending add is discarded, outputs clear at once.
    in_valid = 1'b1;
    a        = 64'd100;
    b        = 64'd200;
    cin      = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_clr", {ovf, cout, sum}, '0);
    check("async_vld", {{(W+1){1'b0}}, out_valid}, '0);
    @(posedge clk);
    #1;
    check("discarded", {ovf, cout, sum}, '0);
    rst_n = 1'b1;
    step(1'b0, '0, '0, 1'b0);
    check("post_rst", {{(W+1){1'b0}}, out_valid}, '0);

    // Random traffic with random gaps.
    for (int i = 0; i < 10000; i++) begin
      step($urandom_range(0, 3) != 0, {$urandom, $urandom}, {$urandom, $urandom},
           1'($urandom_range(0, 1)));
    end

    step(1'b0, '0, '0, 1'b0);
    step(1'b0, '0, '0, 1'b0);
    check("drained", {{(W+1){1'b0}}, exp_q.size() == 0}, {{(W+1){1'b0}}, 1'b1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rca64_adder.md
Name: rca64_adder

Overview:
- 64-bit ripple-carry adder with a registered output stage.
- Combinational core is an explicit chain of WIDTH full-adder cells; carry ripples from bit 0 to bit WIDTH-1.
- Result, carry-out and signed-overflow are captured on the clock edge when the input is qualified by a valid strobe.
- Used as the baseline adder in the datapath, for comparison against faster adder variants.

Parameters:
- WIDTH, 64, operand and sum width in bits. Must be at least 2. All checks use 64.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  qualifies a, b and cin for capture on this rising edge.
- a  input  WIDTH  addend A.
- b  input  WIDTH  addend B.
- cin  input  1  carry into bit 0.
- sum  output  WIDTH  registered sum, a + b + cin mod 2^WIDTH.
- cout  output  1  registered carry out of bit WIDTH-1.
- ovf  output  1  registered two's-complement overflow.
- out_valid  output  1  high for exactly the cycle after each accepted input.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset: while rst_n=0, sum=0, cout=0, ovf=0 and out_valid=0, immediately and independent of clk. First capture is on the first rising edge after rst_n deasserts.
- Core structure:
  - Carry chain c[0]=cin.
  - Per bit i: s[i]=a[i]^b[i]^c[i] and c[i+1]=(a[i]&b[i])|(c[i]&(a[i]^b[i])).
  - Built as instantiated full-adder cells, one per bit, in a generate loop.
  - No behavioural '+' operator and no carry-lookahead.
- Flags: cout_comb=c[WIDTH]; ovf_comb=c[WIDTH]^c[WIDTH-1].
- Capture: at a rising edge with in_valid=1, sum<=s, cout<=cout_comb, ovf<=ovf_comb, out_valid<=1.
- Hold: at a rising edge with in_valid=0, sum, cout and ovf hold their previous values; out_valid<=0.
- Latency: exactly 1 cycle from the in_valid edge to out_valid=1.
- Throughput: one add per cycle. Back-to-back in_valid gives a continuous out_valid with a new result every cycle.
- No backpressure, no internal FSM; the block is always ready.
- Combinational path: WIDTH-cell ripple; the timing path is a -> sum register. No multicycle constraint is applied.
- Reset mid-operation: asserting rst_n low on a cycle where in_valid=1 discards that operation; outputs go to 0 at once.
- Boundaries:
  - Wrap-around: modulo 2^WIDTH; the carry appears only on cout.
  - cin=1 with a=b=all-ones gives sum=all-ones, cout=1.
  - X/Z on inputs while in_valid=0 must not disturb the held outputs.

Test Plan:
- Reset: hold rst_n=0 with random inputs and in_valid toggling -> sum=0, cout=0, ovf=0, out_valid=0 throughout. Release, then present a=1, b=1, cin=0, in_valid=1 -> next cycle sum=2, out_valid=1.
- Basic add: a=64'h000000000123cdef, b=64'h123456789abcdef0, cin=0, in_valid=1 -> after 1 edge sum=64'h123456789BE0ACDF, cout=0, ovf=0, out_valid=1. Following cycle with in_valid=0 -> sum holds, out_valid=0.
- Full carry ripple: a=64'hFFFFFFFFFFFFFFFF, b=0, cin=1 -> sum=0, cout=1, ovf=0. Then a=b=64'hFFFFFFFFFFFFFFFF, cin=1 -> sum=64'hFFFFFFFFFFFFFFFF, cout=1, ovf=0.
- Signed overflow:
  - a=64'h7FFFFFFFFFFFFFFF, b=1, cin=0 -> sum=64'h8000000000000000, cout=0, ovf=1.
  - a=b=64'h8000000000000000 -> sum=0, cout=1, ovf=1.
- Back-to-back: in_valid=1 for 3 consecutive cycles with (1,2,0), (10,20,1), (64'hFFFFFFFFFFFFFFFF,2,0) -> out_valid high 3 cycles; sums 3, 31, 1 in order; couts 0, 0, 1.
- Random: 10,000 random a, b, cin with random in_valid gaps -> every out_valid result matches the 65-bit reference sum {cout,sum}. ovf matches the sign rule (operand signs equal and sum sign differs).
